// File: rtl/da_seq_ctrl.sv
// Distributed-arithmetic sequencer: walks the bit slices of a captured
// activation vector (LSB first) and accumulates the shifted LUT partial sums.
// The MSB slice is the two's-complement sign slice, so it is subtracted.
module da_seq_ctrl #(
  parameter int unsigned DATA_WIDTH_A = 16,
  parameter int unsigned DATA_WIDTH_B = 16,
  parameter int unsigned K            = 9,
  parameter int unsigned LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
  parameter int unsigned ACC_WIDTH    = LUT_WIDTH + 1 + DATA_WIDTH_A
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [K-1:0][DATA_WIDTH_A-1:0]      A,
  output logic                                gen_done,
  output logic [K-1:0]                        bit_slice,
  output logic [7:0]                          t,
  input  logic signed [LUT_WIDTH:0]           lut_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [ACC_WIDTH-1:0]         result,
  output logic                                busy
);

  localparam int unsigned TW     = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam int unsigned EXT_W  = ACC_WIDTH - LUT_WIDTH - 1;
  localparam logic [7:0]  T_LAST = 8'(DATA_WIDTH_A - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [7:0]                      t_q, t_d;
  logic [K-1:0][DATA_WIDTH_A-1:0]  a_q, a_d;

  logic signed [ACC_WIDTH-1:0]     lut_ext;
  logic signed [ACC_WIDTH-1:0]     lut_shift;

  // State, accumulator, slice index and captured operand registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      t_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      a_q     <= a_d;
    end
  end

  // Sign-extend the LUT partial sum and weight it by 2^t
  always_comb begin
    lut_ext   = {{EXT_W{lut_out[LUT_WIDTH]}}, lut_out};
    lut_shift = lut_ext <<< t_q;
  end

  // Next-state logic: accept, per-slice accumulate, hold result until taken
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    t_d     = t_q;
    a_d     = a_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          acc_d   = '0;
          t_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (t_q == T_LAST) begin
          acc_d   = acc_q - lut_shift;
          t_d     = '0;
          state_d = S_DONE;
        end else begin
          acc_d = acc_q + lut_shift;
          t_d   = t_q + 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; slice outputs are zero outside RUN
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    gen_done  = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    result    = acc_q;
    t         = '0;
    bit_slice = '0;
    if (state_q == S_RUN) begin
      t = t_q;
      for (int k = 0; k < int'(K); k++) begin
        bit_slice[k] = a_q[k][t_q[TW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Bench for da_seq_ctrl: LUT modelled as sum of B over set slice bits,
// results checked against a plain dot product of A and B.
module tb_da_seq_ctrl;

  localparam int unsigned DWA  = 16;
  localparam int unsigned DWB  = 16;
  localparam int unsigned KK   = 9;
  localparam int unsigned LW   = DWB + $clog2(KK);
  localparam int unsigned AW   = LW + 1 + DWA;
  localparam int          LAT  = 17;
  localparam int          B2B  = 18;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [KK-1:0][DWA-1:0]      A;
  logic                        gen_done;
  logic [KK-1:0]               bit_slice;
  logic [7:0]                  t;
  logic signed [LW:0]          lut_out;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [AW-1:0]        result;
  logic                        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int a_v[KK];
  int b_v[KK];

  da_seq_ctrl #(
    .DATA_WIDTH_A(DWA), .DATA_WIDTH_B(DWB), .K(KK), .LUT_WIDTH(LW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A),
    .gen_done(gen_done), .bit_slice(bit_slice), .t(t), .lut_out(lut_out),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LUT model: sum of weights whose activation bit is set in this slice
  always_comb begin
    longint s;
    s = 0;
    for (int k = 0; k < int'(KK); k++) begin
      if (bit_slice[k]) s += longint'(b_v[k]);
    end
    lut_out = (LW+1)'(s);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint dot();
    longint s;
    s = 0;
    for (int k = 0; k < int'(KK); k++) s += longint'(a_v[k]) * longint'(b_v[k]);
    return s;
  endfunction

  function automatic longint slice_of(input int bitn);
    longint s;
    s = 0;
    for (int k = 0; k < int'(KK); k++) begin
      if (((a_v[k] >>> bitn) & 1) != 0) s |= (longint'(1) << k);
    end
    return s;
  endfunction

  task automatic drive_a();
    for (int k = 0; k < int'(KK); k++) A[k] = DWA'(a_v[k]);
  endtask

  task automatic scramble_a();
    for (int k = 0; k < int'(KK); k++) A[k] = DWA'($urandom);
  endtask

  task automatic rand_vectors();
    for (int k = 0; k < int'(KK); k++) begin
      a_v[k] = int'($urandom_range(0, 65535)) - 32768;
      b_v[k] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // One full job: accept, run, hold in DONE for 'hold' cycles, then handshake
  task automatic do_job(input string tag, input int hold);
    longint exp_r;
    int     lat;
    exp_r = dot();
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    drive_a();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_a();
    lat = 1;
    check({tag, "_gen_done"}, longint'(gen_done), 1);
    check({tag, "_t0"}, longint'(t), 0);
    check({tag, "_slice0"}, longint'(bit_slice), slice_of(0));
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 6) begin
        check({tag, "_t5"}, longint'(t), 5);
        check({tag, "_slice5"}, longint'(bit_slice), slice_of(5));
      end
    end
    check({tag, "_latency"}, longint'(lat), LAT);
    check({tag, "_result"}, longint'(result), exp_r);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      scramble_a();
      @(negedge clk);
      check({tag, "_hold_valid"}, longint'(out_valid), 1);
      check({tag, "_hold_result"}, longint'(result), exp_r);
      check({tag, "_hold_in_ready"}, longint'(in_ready), 0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, longint'(out_valid), 0);
    check({tag, "_post_in_ready"}, longint'(in_ready), 1);
    check({tag, "_post_busy"}, longint'(busy), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int     acc_cyc[4];
    longint exp_q[$];
    int     seen;
    int     wait_n;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0;
    for (int k = 0; k < int'(KK); k++) begin a_v[k] = 0; b_v[k] = 0; end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_gen_done", longint'(gen_done), 0);
    check("rst_result", longint'(result), 0);
    check("rst_t", longint'(t), 0);
    check("rst_slice", longint'(bit_slice), 0);
    rst = 1'b1;
    @(negedge clk);

    // All ones times two
    for (int k = 0; k < int'(KK); k++) begin a_v[k] = 1; b_v[k] = 2; end
    check("ones_model", dot(), 18);
    do_job("ones", 0);

    // Sign slice subtract
    for (int k = 0; k < int'(KK); k++) begin
      a_v[k] = 0; b_v[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    a_v[0] = -1; b_v[0] = 3;
    do_job("neg", 0);

    // Extreme magnitudes
    for (int k = 0; k < int'(KK); k++) begin a_v[k] = -32768; b_v[k] = 32767; end
    check("extreme_model", dot(), -longint'(9) * 32768 * 32767);
    do_job("extreme", 0);

    // Back-pressure in DONE
    rand_vectors();
    do_job("stall5", 5);

    // Random jobs with random back-pressure
    for (int j = 0; j < 6; j++) begin
      rand_vectors();
      do_job($sformatf("rand%0d", j), int'($urandom_range(0, 3)));
    end

    // Reset mid-run at slice 7
    rand_vectors();
    drive_a();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_n = 0;
    while (t != 8'd7 && wait_n < 40) begin @(negedge clk); wait_n++; end
    check("midrst_reach_t7", longint'(t), 7);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_result", longint'(result), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_output", longint'(seen), 0);
    rand_vectors();
    do_job("after_rst", 1);

    // Back-to-back jobs, in_valid and out_ready held high
    for (int k = 0; k < int'(KK); k++) b_v[k] = int'($urandom_range(0, 65535)) - 32768;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_n = 0;
      while (!in_ready && wait_n < 40) begin @(negedge clk); wait_n++; end
      check($sformatf("b2b%0d_accept", j), longint'(in_ready), 1);
      acc_cyc[j] = cyc;
      for (int k = 0; k < int'(KK); k++) a_v[k] = int'($urandom_range(0, 65535)) - 32768;
      drive_a();
      exp_q.push_back(dot());
      if (j > 0) check($sformatf("b2b%0d_spacing", j), longint'(acc_cyc[j] - acc_cyc[j-1]), B2B);
      @(negedge clk);
      scramble_a();
      wait_n = 0;
      while (!out_valid && wait_n < 40) begin @(negedge clk); wait_n++; end
      check($sformatf("b2b%0d_valid", j), longint'(out_valid), 1);
      check($sformatf("b2b%0d_result", j), longint'(result), exp_q.pop_front());
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("final_idle", longint'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
